// File: rtl/if_stage.sv
// Instruction-fetch stage: one outstanding word fetch, a single-entry output buffer
// toward ID, and redirect handling that drops wrong-path words and in-flight responses.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [31:0] PC,
  output logic [31:0] Inst,
  output logic        right_valid,
  input  logic        right_ready
);

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    DISCARD
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] req_pc;
  logic        valid;
  logic        right_fire;
  logic        req_accept;
  logic        load;

  // A request only goes out when the buffer has room, so a returning word never waits.
  assign right_fire  = valid & right_ready;
  assign inst_req    = (state == REQ) & (~valid | right_fire) & ~br_taken;
  assign inst_addr   = pc;
  assign req_accept  = inst_req & inst_addr_ok;
  assign load        = (state == WAIT) & inst_data_ok & ~br_taken;
  assign right_valid = valid;

  always_comb begin
    state_next = state;
    case (state)
      REQ:     if (req_accept) state_next = WAIT;
      WAIT: begin
        if (inst_data_ok)  state_next = REQ;
        else if (br_taken) state_next = DISCARD;
      end
      DISCARD: if (inst_data_ok) state_next = REQ;
      default: state_next = REQ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= REQ;
    else        state <= state_next;
  end

  // Redirect wins over sequential advance; target low bits are simply masked off.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc     <= RESET_PC;
      req_pc <= 32'h0;
    end else begin
      if (br_taken)  pc <= br_target & 32'hFFFF_FFFC;
      else if (load) pc <= req_pc + 32'd4;
      if (req_accept) req_pc <= pc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      PC    <= 32'h0;
      Inst  <= 32'h0;
    end else begin
      if (br_taken)        valid <= 1'b0;
      else if (load)       valid <= 1'b1;
      else if (right_fire) valid <= 1'b0;
      if (load) begin
        PC   <= req_pc;
        Inst <= inst_rdata;
      end
    end
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the in-order core. Holds the architectural PC and issues one word fetch at a time to the instruction RAM. It buffers each returned word together with its PC and presents the pair to the ID stage over the valid/ready handshake. Branch redirects from later stages flush the wrong-path word and any in-flight response.

## Interface
- RESET_PC, 32'h1c00_0000, PC loaded on reset (word aligned).
- clk  in  1  core clock, all state updates on posedge.
- reset  in  1  asynchronous, active-low; reset == 0 forces reset state immediately.
- inst_req  out  1  fetch request to instruction RAM.
- inst_addr  out  32  fetch address; valid while inst_req = 1.
- inst_addr_ok  in  1  RAM accepts the request this cycle (handshake with inst_req).
- inst_data_ok  in  1  RAM returns data for the accepted request this cycle.
- inst_rdata  in  32  returned instruction word; valid with inst_data_ok.
- br_taken  in  1  single-cycle redirect pulse from EXE.
- br_target  in  32  redirect PC; valid with br_taken.
- PC  out  32  PC of the instruction presented to ID.
- Inst  out  32  instruction presented to ID.
- right_valid  out  1  PC/Inst hold a valid instruction.
- right_ready  in  1  ID can accept (ID left_ready).

## Operation
- State registers:
  - pc: next fetch address.
  - req_pc: address of the outstanding request.
  - state: REQ, WAIT, DISCARD.
  - Output buffer: valid, PC, Inst.
- right_fire = right_valid & right_ready.
- inst_addr = pc.
- inst_req = (state == REQ) & (~valid | right_fire) & ~br_taken.
  - At most one request outstanding.
  - A request issues only when the output buffer is empty or draining, so a returning word always has a free slot.
- REQ:
  - On inst_req & inst_addr_ok: req_pc <= pc, go to WAIT.
  - inst_data_ok in REQ is ignored.
- WAIT, inst_data_ok & ~br_taken:
  - Inst <= inst_rdata, PC <= req_pc, valid <= 1.
  - pc <= req_pc + 4, with 32-bit wrap: 32'hFFFF_FFFC + 4 = 0.
  - Go to REQ.
- WAIT, br_taken & ~inst_data_ok: go to DISCARD.
- WAIT, br_taken & inst_data_ok: drop the data, go to REQ.
- DISCARD:
  - On inst_data_ok: drop the data, go to REQ.
  - br_taken here only updates pc.
- Output buffer, in priority order:
  - br_taken → valid <= 0. This holds in every state and even if right_fire is set the same cycle, because ID is flushed by the same redirect.
  - Else right_fire & no new data → valid <= 0.
  - Else the new word loads. A simultaneous right_fire and load gives valid stays 1 with new contents.
- Redirect: br_taken → pc <= {br_target[31:2], 2'b00}. Low bits are dropped; no alignment exception is raised in this stage.
- Stall: while valid & ~right_ready, PC/Inst/right_valid stay stable, and no new request issues.

## Timing
- Reset (reset == 0, asynchronous):
  - state = REQ, pc = RESET_PC, req_pc = 0.
  - valid = 0, PC = 0, Inst = 0.
  - inst_req asserts combinationally in the first cycle after release.
- Reset asserted mid-operation discards everything, including the outstanding request. The instruction RAM shares the same reset and returns nothing after it.
- Latency with a 1-cycle RAM (addr_ok in cycle t, data_ok in t+1):
  - right_valid rises at t+2.
  - The next request issues at t+2 if ID consumes; peak throughput is 1 instruction per 2 cycles.
- Redirect in cycle t:
  - The first request to the target issues at t+1 if state is REQ at t+1.
  - Otherwise it issues the cycle after the discarded response returns.
- right_ready → inst_req is a combinational path. No path exists from inst_rdata to any output.

## Test plan
- Reset/sequential fetch:
  - Stimulus: reset low 3 cycles, then release. RAM: addr_ok = 1 always, data_ok the next cycle, rdata = addr ^ 32'hA5A5_A5A5. right_ready = 1.
  - Required: inst_addr sequence 1c000000, 1c000004, 1c000008. Each pair reaches PC/Inst 2 cycles after its request. right_valid = 0 during reset.
- Backpressure:
  - Stimulus: right_ready = 0 for 5 cycles after the first word arrives.
  - Required: PC = 1c000000 held, Inst stable, inst_req = 0 throughout. The next request (1c000004) issues in the same cycle right_ready returns to 1.
- Redirect while waiting:
  - Stimulus: br_taken with target 1c000100 in WAIT; data_ok 3 cycles later.
  - Required: the word is dropped, right_valid stays 0, and the next inst_addr = 1c000100.
- Redirect same cycle as data_ok and right_fire:
  - Required: the data is dropped, right_valid = 0 next cycle, inst_addr = target next cycle.
- Slow RAM:
  - Stimulus: inst_addr_ok low 4 cycles.
  - Required: inst_req/inst_addr held at 1c000000 until accepted, with no duplicate acceptance.
- Wrap and misaligned target:
  - Stimulus: br_target = 32'hFFFF_FFFE.
  - Required: fetches at FFFFFFFC, then 00000000.
